execute_operand_forwarder: RTL and testbench

Operand resolution stage sitting between register-file read and the execute units; the consumer side of the execute forwarding register path. Keeps a short history of recent general-register writebacks, and a scoreboard of registers with outstanding long-latency (load) writes. Each accepted operand request gets the newest value of SRC0, SRC1 and SPR. Results go into an output register with valid/busy backpressure. Requests whose source is still pending are stalled.

---
 rtl/execute_operand_forwarder.sv | 167 ++++++++++++++++
 tb/tb_execute_operand_forwarder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_operand_forwarder.sv
// execute_operand_forwarder: resolves SRC0/SRC1/SPR operands for the execute stage from
// same-cycle writeback bypass, a short writeback history and register-file data, stalls
// requests whose GR source has an outstanding load, and registers the result with
// valid/busy backpressure.
// Optional feature macro: MIST1032ISA_FWD_HISTORY_EN (defined: P_HISTORY_DEPTH history
// entries; undefined: a single entry, i.e. the plain forwarding register).
module execute_operand_forwarder #(
  parameter int unsigned P_HISTORY_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iWB_GR_VALID,
  input  logic [31:0] iWB_GR_DATA,
  input  logic [4:0]  iWB_GR_DEST,
  input  logic        iWB_GR_DEST_SYSREG,
  input  logic        iFDR_SPR_VALID,
  input  logic [31:0] iFDR_SPR_DATA,
  input  logic        iPEND_VALID,
  input  logic [4:0]  iPEND_DEST,
  input  logic        iREQ_VALID,
  output logic        oREQ_BUSY,
  input  logic [4:0]  iREQ_SRC0_NUM,
  input  logic [4:0]  iREQ_SRC1_NUM,
  input  logic        iREQ_SRC0_SYSREG,
  input  logic        iREQ_SRC1_SYSREG,
  input  logic [31:0] iREQ_SRC0_RF_DATA,
  input  logic [31:0] iREQ_SRC1_RF_DATA,
  input  logic [31:0] iREQ_SPR_RF_DATA,
  output logic        oOUT_VALID,
  input  logic        iOUT_BUSY,
  output logic [31:0] oOUT_SRC0,
  output logic [31:0] oOUT_SRC1,
  output logic [31:0] oOUT_SPR
);

`ifdef MIST1032ISA_FWD_HISTORY_EN
  localparam int unsigned Depth = P_HISTORY_DEPTH;
`else
  // Pinned to one entry; the parameter only matters when the history is enabled.
  localparam int unsigned Depth = (P_HISTORY_DEPTH != 0) ? 1 : 1;
`endif

  logic [Depth-1:0] hist_valid_q;
  logic [Depth-1:0] hist_sysreg_q;
  logic [31:0]      hist_data_q [Depth];
  logic [4:0]       hist_dest_q [Depth];

  logic [31:0] sb_q, sb_d;

  logic        out_valid_q;
  logic [31:0] out_src0_q, out_src1_q, out_spr_q;

  logic        bypass0, bypass1;
  logic        hazard0, hazard1;
  logic [31:0] src0, src1, spr;
  logic        accept;

  // Same-cycle writeback bypass and load-hazard detection per source.
  always_comb begin
    bypass0 = iWB_GR_VALID && (iWB_GR_DEST == iREQ_SRC0_NUM) &&
              (iWB_GR_DEST_SYSREG == iREQ_SRC0_SYSREG);
    bypass1 = iWB_GR_VALID && (iWB_GR_DEST == iREQ_SRC1_NUM) &&
              (iWB_GR_DEST_SYSREG == iREQ_SRC1_SYSREG);
    // Scoreboard tracks GRs only, so a sysreg source never stalls.
    hazard0 = !iREQ_SRC0_SYSREG && sb_q[iREQ_SRC0_NUM] && !bypass0;
    hazard1 = !iREQ_SRC1_SYSREG && sb_q[iREQ_SRC1_NUM] && !bypass1;
    oREQ_BUSY = hazard0 || hazard1 || (out_valid_q && iOUT_BUSY);
    accept    = iREQ_VALID && !oREQ_BUSY;
  end

  // Operand selection: bypass beats history, lower history index beats higher, then RF.
  always_comb begin
    src0 = iREQ_SRC0_RF_DATA;
    src1 = iREQ_SRC1_RF_DATA;
    // Walk oldest to newest so the newest match is the one left standing.
    for (int i = int'(Depth) - 1; i >= 0; i--) begin
      if (hist_valid_q[i] && (hist_dest_q[i] == iREQ_SRC0_NUM) &&
          (hist_sysreg_q[i] == iREQ_SRC0_SYSREG)) begin
        src0 = hist_data_q[i];
      end
      if (hist_valid_q[i] && (hist_dest_q[i] == iREQ_SRC1_NUM) &&
          (hist_sysreg_q[i] == iREQ_SRC1_SYSREG)) begin
        src1 = hist_data_q[i];
      end
    end
    if (bypass0) src0 = iWB_GR_DATA;
    if (bypass1) src1 = iWB_GR_DATA;
    spr = iFDR_SPR_VALID ? iFDR_SPR_DATA : iREQ_SPR_RF_DATA;
  end

  // Scoreboard next state: a pending mark wins over a same-cycle clear.
  always_comb begin
    sb_d = sb_q;
    if (iWB_GR_VALID && !iWB_GR_DEST_SYSREG) sb_d[iWB_GR_DEST] = 1'b0;
    if (iPEND_VALID) sb_d[iPEND_DEST] = 1'b1;
  end

  // Writeback history shift register; entry 0 is the newest writeback.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      hist_valid_q  <= '0;
      hist_sysreg_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        hist_data_q[i] <= '0;
        hist_dest_q[i] <= '0;
      end
    end else if (iRESET_SYNC) begin
      hist_valid_q  <= '0;
      hist_sysreg_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        hist_data_q[i] <= '0;
        hist_dest_q[i] <= '0;
      end
    end else if (iWB_GR_VALID) begin
      hist_valid_q[0]  <= 1'b1;
      hist_sysreg_q[0] <= iWB_GR_DEST_SYSREG;
      hist_data_q[0]   <= iWB_GR_DATA;
      hist_dest_q[0]   <= iWB_GR_DEST;
      for (int i = 1; i < int'(Depth); i++) begin
        hist_valid_q[i]  <= hist_valid_q[i-1];
        hist_sysreg_q[i] <= hist_sysreg_q[i-1];
        hist_data_q[i]   <= hist_data_q[i-1];
        hist_dest_q[i]   <= hist_dest_q[i-1];
      end
    end
  end

  // Pending-load scoreboard register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      sb_q <= '0;
    end else if (iRESET_SYNC) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Output register: load on accept, drop valid once downstream takes it.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      out_valid_q <= 1'b0;
      out_src0_q  <= '0;
      out_src1_q  <= '0;
      out_spr_q   <= '0;
    end else if (iRESET_SYNC) begin
      out_valid_q <= 1'b0;
      out_src0_q  <= '0;
      out_src1_q  <= '0;
      out_spr_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_src0_q  <= src0;
      out_src1_q  <= src1;
      out_spr_q   <= spr;
    end else if (!iOUT_BUSY) begin
      out_valid_q <= 1'b0;
    end
  end

  assign oOUT_VALID = out_valid_q;
  assign oOUT_SRC0  = out_src0_q;
  assign oOUT_SRC1  = out_src1_q;
  assign oOUT_SPR   = out_spr_q;

endmodule

// File: tb/tb_execute_operand_forwarder.sv
// Bench for execute_operand_forwarder: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_execute_operand_forwarder;

`ifdef MIST1032ISA_FWD_HISTORY_EN
  localparam int Depth = 4;
`else
  localparam int Depth = 1;
`endif

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC = 1'b0;
  logic        iWB_GR_VALID = 1'b0;
  logic [31:0] iWB_GR_DATA = '0;
  logic [4:0]  iWB_GR_DEST = '0;
  logic        iWB_GR_DEST_SYSREG = 1'b0;
  logic        iFDR_SPR_VALID = 1'b0;
  logic [31:0] iFDR_SPR_DATA = '0;
  logic        iPEND_VALID = 1'b0;
  logic [4:0]  iPEND_DEST = '0;
  logic        iREQ_VALID = 1'b0;
  logic        oREQ_BUSY;
  logic [4:0]  iREQ_SRC0_NUM = '0;
  logic [4:0]  iREQ_SRC1_NUM = '0;
  logic        iREQ_SRC0_SYSREG = 1'b0;
  logic        iREQ_SRC1_SYSREG = 1'b0;
  logic [31:0] iREQ_SRC0_RF_DATA = '0;
  logic [31:0] iREQ_SRC1_RF_DATA = '0;
  logic [31:0] iREQ_SPR_RF_DATA = '0;
  logic        oOUT_VALID;
  logic        iOUT_BUSY = 1'b0;
  logic [31:0] oOUT_SRC0, oOUT_SRC1, oOUT_SPR;

  execute_operand_forwarder #(.P_HISTORY_DEPTH(4)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iWB_GR_VALID(iWB_GR_VALID), .iWB_GR_DATA(iWB_GR_DATA), .iWB_GR_DEST(iWB_GR_DEST),
    .iWB_GR_DEST_SYSREG(iWB_GR_DEST_SYSREG),
    .iFDR_SPR_VALID(iFDR_SPR_VALID), .iFDR_SPR_DATA(iFDR_SPR_DATA),
    .iPEND_VALID(iPEND_VALID), .iPEND_DEST(iPEND_DEST),
    .iREQ_VALID(iREQ_VALID), .oREQ_BUSY(oREQ_BUSY),
    .iREQ_SRC0_NUM(iREQ_SRC0_NUM), .iREQ_SRC1_NUM(iREQ_SRC1_NUM),
    .iREQ_SRC0_SYSREG(iREQ_SRC0_SYSREG), .iREQ_SRC1_SYSREG(iREQ_SRC1_SYSREG),
    .iREQ_SRC0_RF_DATA(iREQ_SRC0_RF_DATA), .iREQ_SRC1_RF_DATA(iREQ_SRC1_RF_DATA),
    .iREQ_SPR_RF_DATA(iREQ_SPR_RF_DATA),
    .oOUT_VALID(oOUT_VALID), .iOUT_BUSY(iOUT_BUSY),
    .oOUT_SRC0(oOUT_SRC0), .oOUT_SRC1(oOUT_SRC1), .oOUT_SPR(oOUT_SPR)
  );

  always #5 iCLOCK = ~iCLOCK;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        sys;
  } wb_t;

  wb_t         hist[$];          // newest first, at most Depth entries
  bit          pending[32];      // GRs with an outstanding load
  logic        m_valid;
  logic [31:0] m_s0, m_s1, m_spr;

  function automatic void m_clear();
    hist.delete();
    foreach (pending[i]) pending[i] = 1'b0;
    m_valid = 1'b0;
    m_s0 = '0;
    m_s1 = '0;
    m_spr = '0;
  endfunction

  function automatic logic [31:0] m_resolve(input logic [4:0] num, input logic sys,
                                            input logic [31:0] rf);
    if (iWB_GR_VALID && iWB_GR_DEST == num && iWB_GR_DEST_SYSREG == sys) return iWB_GR_DATA;
    foreach (hist[i]) if (hist[i].dest == num && hist[i].sys == sys) return hist[i].data;
    return rf;
  endfunction

  function automatic bit m_stalled(input logic [4:0] num, input logic sys);
    if (sys) return 1'b0;
    if (!pending[num]) return 1'b0;
    return !(iWB_GR_VALID && !iWB_GR_DEST_SYSREG && iWB_GR_DEST == num);
  endfunction

  function automatic bit m_busy();
    return m_stalled(iREQ_SRC0_NUM, iREQ_SRC0_SYSREG) ||
           m_stalled(iREQ_SRC1_NUM, iREQ_SRC1_SYSREG) || (m_valid && iOUT_BUSY);
  endfunction

  always @(negedge inRESET) m_clear();

  always @(posedge iCLOCK) begin
    if (!inRESET || iRESET_SYNC) begin
      m_clear();
    end else begin
      if (iREQ_VALID && !m_busy()) begin
        m_valid = 1'b1;
        m_s0  = m_resolve(iREQ_SRC0_NUM, iREQ_SRC0_SYSREG, iREQ_SRC0_RF_DATA);
        m_s1  = m_resolve(iREQ_SRC1_NUM, iREQ_SRC1_SYSREG, iREQ_SRC1_RF_DATA);
        m_spr = iFDR_SPR_VALID ? iFDR_SPR_DATA : iREQ_SPR_RF_DATA;
      end else if (!iOUT_BUSY) begin
        m_valid = 1'b0;
      end
      if (iWB_GR_VALID) begin
        hist.push_front('{data: iWB_GR_DATA, dest: iWB_GR_DEST, sys: iWB_GR_DEST_SYSREG});
        if (hist.size() > Depth) void'(hist.pop_back());
        if (!iWB_GR_DEST_SYSREG) pending[iWB_GR_DEST] = 1'b0;
      end
      if (iPEND_VALID) pending[iPEND_DEST] = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge iCLOCK) begin
    if (cmp_en) begin
      check("model_busy", {31'b0, oREQ_BUSY}, {31'b0, m_busy()});
      check("model_valid", {31'b0, oOUT_VALID}, {31'b0, m_valid});
      check("model_src0", oOUT_SRC0, m_s0);
      check("model_src1", oOUT_SRC1, m_s1);
      check("model_spr", oOUT_SPR, m_spr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge iCLOCK);
    #1;
  endtask

  task automatic idle();
    iWB_GR_VALID = 0; iPEND_VALID = 0; iREQ_VALID = 0; iOUT_BUSY = 0; iFDR_SPR_VALID = 0;
    iREQ_SRC0_SYSREG = 0; iREQ_SRC1_SYSREG = 0; iWB_GR_DEST_SYSREG = 0;
    iREQ_SRC0_NUM = 0; iREQ_SRC1_NUM = 0;
    iREQ_SRC0_RF_DATA = 0; iREQ_SRC1_RF_DATA = 0; iREQ_SPR_RF_DATA = 0;
  endtask

  task automatic sreset();
    idle();
    iRESET_SYNC = 1;
    step();
    iRESET_SYNC = 0;
  endtask

  task automatic wb(input logic [4:0] d, input logic [31:0] v, input logic s);
    iWB_GR_VALID = 1; iWB_GR_DEST = d; iWB_GR_DATA = v; iWB_GR_DEST_SYSREG = s;
  endtask

  task automatic req(input logic [4:0] n0, input logic s0, input logic [31:0] rf0,
                     input logic [4:0] n1, input logic s1, input logic [31:0] rf1);
    iREQ_VALID = 1;
    iREQ_SRC0_NUM = n0; iREQ_SRC0_SYSREG = s0; iREQ_SRC0_RF_DATA = rf0;
    iREQ_SRC1_NUM = n1; iREQ_SRC1_SYSREG = s1; iREQ_SRC1_RF_DATA = rf1;
  endtask

  initial begin
    idle();
    inRESET = 0;
    repeat (2) step();
    inRESET = 1;
    cmp_en = 1;
    step();

    // Reset state
    check("rst_valid", {31'b0, oOUT_VALID}, 32'd0);
    check("rst_busy", {31'b0, oREQ_BUSY}, 32'd0);
    check("rst_src0", oOUT_SRC0, 32'd0);

    // Bypass priority over history, then history visibility
    sreset();
    wb(3, 32'h11, 0);
    step();
    wb(3, 32'h22, 0);
    req(3, 0, 32'h0, 0, 0, 32'h0);
    iREQ_SPR_RF_DATA = 32'h5A5A;
    step();
    iWB_GR_VALID = 0;
    check("byp_valid", {31'b0, oOUT_VALID}, 32'd1);
    check("byp_src0", oOUT_SRC0, 32'h22);
    check("spr_rf", oOUT_SPR, 32'h5A5A);
    iFDR_SPR_VALID = 1; iFDR_SPR_DATA = 32'hCAFE;
    step();
    check("hist_src0", oOUT_SRC0, 32'h22);
    check("spr_fdr", oOUT_SPR, 32'hCAFE);

    // Sysreg and GR with the same number are distinct
    sreset();
    wb(3, 32'hAA, 1);
    step();
    iWB_GR_VALID = 0;
    req(3, 0, 32'h55, 3, 1, 32'h0);
    step();
    check("sys_gr_src0", oOUT_SRC0, 32'h55);
    check("sys_sr_src1", oOUT_SRC1, 32'hAA);

    // Load stall released by the writeback bypass
    sreset();
    iPEND_VALID = 1; iPEND_DEST = 5;
    step();
    iPEND_VALID = 0;
    req(0, 0, 32'h0, 5, 0, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("ld_busy", {31'b0, oREQ_BUSY}, 32'd1);
      step();
    end
    check("ld_novalid", {31'b0, oOUT_VALID}, 32'd0);
    wb(5, 32'h1234, 0);
    at_neg();
    check("ld_accept", {31'b0, oREQ_BUSY}, 32'd0);
    step();
    idle();
    check("ld_src1", oOUT_SRC1, 32'h1234);

    // Backpressure holds outputs stable
    sreset();
    req(0, 0, 32'h10, 0, 0, 32'h0);
    step();
    iOUT_BUSY = 1;
    req(0, 0, 32'h20, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("bp_busy", {31'b0, oREQ_BUSY}, 32'd1);
      check("bp_hold", oOUT_SRC0, 32'h10);
      step();
    end
    iOUT_BUSY = 0;
    at_neg();
    check("bp_release", {31'b0, oREQ_BUSY}, 32'd0);
    step();
    iREQ_VALID = 0;
    check("bp_new", oOUT_SRC0, 32'h20);

    // Depth edge: oldest writeback drops out of the history
    sreset();
    for (int k = 1; k <= 5; k++) begin
      wb(5'(k), 32'(k), 0);
      step();
    end
    iWB_GR_VALID = 0;
    req(1, 0, 32'h99, 0, 0, 32'h0);
    step();
    check("depth_r1", oOUT_SRC0, 32'h99);
    req(2, 0, 32'h77, 0, 0, 32'h0);
    step();
    iREQ_VALID = 0;
    check("depth_r2", oOUT_SRC0, (Depth >= 4) ? 32'h2 : 32'h77);

    // Asynchronous reset mid-run clears outputs, history and scoreboard
    sreset();
    wb(7, 32'h77, 0);
    iPEND_VALID = 1; iPEND_DEST = 9;
    req(1, 0, 32'h42, 0, 0, 32'h0);
    step();
    idle();
    iOUT_BUSY = 1;
    inRESET = 0;
    at_neg();
    check("arst_valid", {31'b0, oOUT_VALID}, 32'd0);
    check("arst_src0", oOUT_SRC0, 32'd0);
    check("arst_busy", {31'b0, oREQ_BUSY}, 32'd0);
    step();
    inRESET = 1;
    iOUT_BUSY = 0;
    req(7, 0, 32'h42, 9, 0, 32'h43);
    at_neg();
    check("arst_nostall", {31'b0, oREQ_BUSY}, 32'd0);
    step();
    idle();
    check("arst_rf0", oOUT_SRC0, 32'h42);
    check("arst_rf1", oOUT_SRC1, 32'h43);

    // Randomized traffic over a small register window to provoke matches and hazards
    for (int c = 0; c < 3000; c++) begin
      iRESET_SYNC        = ($urandom_range(0, 199) == 0);
      iWB_GR_VALID       = ($urandom_range(0, 9) < 4);
      iWB_GR_DEST        = 5'($urandom_range(0, 7));
      iWB_GR_DATA        = $urandom;
      iWB_GR_DEST_SYSREG = ($urandom_range(0, 7) == 0);
      iPEND_VALID        = ($urandom_range(0, 9) == 0);
      iPEND_DEST         = 5'($urandom_range(0, 7));
      iFDR_SPR_VALID     = $urandom_range(0, 1);
      iFDR_SPR_DATA      = $urandom;
      iOUT_BUSY          = ($urandom_range(0, 9) < 3);
      iREQ_VALID         = ($urandom_range(0, 9) < 7);
      iREQ_SRC0_NUM      = 5'($urandom_range(0, 7));
      iREQ_SRC1_NUM      = 5'($urandom_range(0, 7));
      iREQ_SRC0_SYSREG   = ($urandom_range(0, 7) == 0);
      iREQ_SRC1_SYSREG   = ($urandom_range(0, 7) == 0);
      iREQ_SRC0_RF_DATA  = $urandom;
      iREQ_SRC1_RF_DATA  = $urandom;
      iREQ_SPR_RF_DATA   = $urandom;
      step();
    end
    iRESET_SYNC = 0;
    idle();
    step();
    cmp_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
